inst_encoder: RTL

- Inverse of the core's immediate decode path: packs field-level instruction descriptions (format, opcode, registers, functs, full 32-bit signed immediate) into RV32I 32-bit instruction words.
- Sits between the test/boot loader and IMEM write port.
- Assigns sequential word addresses to each emitted instruction.
- Registered encode stage feeds a 2-entry output FIFO, with valid/ready handshakes on both sides.

---
 rtl/inst_encoder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs field descriptors into 32-bit words behind a 2-entry output FIFO.
// Optional immediate range checking is enabled by defining INST_ENC_IMM_CHECK_EN.
module inst_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] mem_inst [2];
    logic        mem_err  [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        ready_en;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        fmt_ok;
    logic        imm_ok;

    always_comb begin
        enc_word = NOP;
        fmt_ok   = 1'b1;
        case (in_fmt)
            3'd0: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            3'd1: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            3'd2: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            3'd3: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                              in_imm[4:1], in_imm[11], in_opcode};
            3'd4: enc_word = {in_imm[31:12], in_rd, in_opcode};
            3'd5: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            default: fmt_ok = 1'b0;
        endcase
    end

`ifdef INST_ENC_IMM_CHECK_EN
    // A signed range [-2^k, 2^k-1] holds exactly when all bits above bit k-1 equal the sign bit.
    always_comb begin
        imm_ok = 1'b1;
        case (in_fmt)
            3'd1, 3'd2: imm_ok = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
            3'd3: imm_ok = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
            3'd4: imm_ok = (in_imm[11:0] == '0);
            3'd5: imm_ok = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
            default: imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign enc_err   = !(fmt_ok && imm_ok);
    assign out_valid = (count != 2'd0);
    assign in_ready  = ready_en && !restart && ((count != 2'd2) || (out_valid && out_ready));
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !restart;
    assign out_inst  = out_valid ? mem_inst[rd_ptr] : 32'h0;
    assign out_err   = out_valid ? mem_err[rd_ptr] : 1'b0;

    // Push and pop may share a slot when full; the head is read before being overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_inst[0] <= '0;
            mem_inst[1] <= '0;
            mem_err[0]  <= 1'b0;
            mem_err[1]  <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            ready_en    <= 1'b0;
            out_addr    <= BASE_ADDR;
            err_cnt     <= 8'd0;
        end else begin
            ready_en <= 1'b1;
            if (restart) begin
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                count    <= 2'd0;
                out_addr <= BASE_ADDR;
            end else begin
                if (push) begin
                    mem_inst[wr_ptr] <= enc_err ? NOP : enc_word;
                    mem_err[wr_ptr]  <= enc_err;
                    wr_ptr           <= ~wr_ptr;
                    if (enc_err && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end
                if (pop) begin
                    rd_ptr   <= ~rd_ptr;
                    out_addr <= out_addr + ADDR_STEP;
                end
                if (push && !pop)
                    count <= count + 2'd1;
                else if (pop && !push)
                    count <= count - 2'd1;
            end
        end
    end

endmodule
